// File: rtl/pixel_mem_pkg.sv
// Purpose: shared constants and state type for the pixel memory write path.
//   PIX_DEPTH  : words per bank
//   PIX_ADDR_W : port A address width
//   PIX_DATA_W : pixel / memory data width
//   loader_state_t : pixel_mem_loader FSM states
package pixel_mem_pkg;

  localparam int unsigned PIX_DEPTH  = 512;
  localparam int unsigned PIX_ADDR_W = 9;
  localparam int unsigned PIX_DATA_W = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

endpackage : pixel_mem_pkg

// File: rtl/pixel_mem_loader.sv
// Purpose: writes a valid/ready pixel stream sequentially into port A of the
// dual-bank pixel memory, ping-ponging banks with the downstream consumer.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   pix_data        : incoming pixel
//   pix_valid       : pix_data valid
//   pix_sof         : start-of-frame, qualified by pix_valid
//   pix_ready       : loader accepts a pixel this cycle (combinational)
//   consumer_done   : pulse, consumer released the bank it holds
//   address_a       : port A address (registered)
//   data_a          : port A write data (registered)
//   wren_a          : port A write enable (registered)
//   select          : bank being written; consumer reads ~select
//   bank_ready      : pulse, bank ~select handed to the consumer
module pixel_mem_loader
  import pixel_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = PIX_DEPTH,
  parameter int unsigned ADDR_W = PIX_ADDR_W,
  parameter int unsigned DATA_W = PIX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              consumer_done,
  output logic [ADDR_W-1:0] address_a,
  output logic [DATA_W-1:0] data_a,
  output logic              wren_a,
  output logic              select,
  output logic              bank_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     r_state;
  loader_state_t     w_next_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_held;
  logic              r_select;
  logic [ADDR_W-1:0] r_address_a;
  logic [DATA_W-1:0] r_data_a;
  logic              r_wren_a;
  logic              r_bank_ready;
  logic              w_accept;
  logic              w_swap;

  // Next-state, handshake and swap decision
  always_comb begin
    w_next_state = r_state;
    pix_ready    = 1'b0;
    w_accept     = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      FILL: begin
        pix_ready = ~rst;
        w_accept  = pix_valid & ~rst;
        // sof restarts the bank, so it wins over completion
        if (w_accept && !pix_sof && (r_wr_ptr == LAST_ADDR)) begin
          w_next_state = FLUSH;
        end
      end
      FLUSH: begin
        // last word is on port A this cycle; swap lands the cycle after
        if (!r_held || consumer_done) begin
          w_swap       = 1'b1;
          w_next_state = FILL;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (consumer_done) begin
          w_swap       = 1'b1;
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  // State, pointer, ownership and registered port A outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_held       <= 1'b0;
      r_select     <= 1'b0;
      r_address_a  <= '0;
      r_data_a     <= '0;
      r_wren_a     <= 1'b0;
      r_bank_ready <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wren_a     <= w_accept;
      r_bank_ready <= w_swap;
      if (w_accept) begin
        r_data_a <= pix_data;
        if (pix_sof) begin
          // abandon the partial bank in place, restart at address 0
          r_address_a <= '0;
          r_wr_ptr    <= ADDR_W'(1);
        end else begin
          r_address_a <= r_wr_ptr;
          r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        end
      end
      if ((r_state == FILL) && consumer_done) begin
        r_held <= 1'b0;
      end
      if (w_swap) begin
        r_select <= ~r_select;
        r_held   <= 1'b1;
        r_wr_ptr <= '0;
      end
    end
  end

  assign address_a  = r_address_a;
  assign data_a     = r_data_a;
  assign wren_a     = r_wren_a;
  assign select     = r_select;
  assign bank_ready = r_bank_ready;

endmodule : pixel_mem_loader

// File: tb/tb_pixel_mem_loader.sv
// Purpose: self-checking bench for pixel_mem_loader. A bank-level reference
// model (pixel counts, ownership flag, pending full bank) predicts every
// port A write, bank handover and pix_ready value cycle by cycle.
module tb_pixel_mem_loader;

  localparam int DEPTH = 512;

  logic        clk;
  logic        rst;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic        consumer_done;
  logic [8:0]  address_a;
  logic [15:0] data_a;
  logic        wren_a;
  logic        select;
  logic        bank_ready;

  pixel_mem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .consumer_done(consumer_done),
    .address_a    (address_a),
    .data_a       (data_a),
    .wren_a       (wren_a),
    .select       (select),
    .bank_ready   (bank_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;

  // reference model
  logic        m_sel;
  logic        m_own;     // consumer holds bank ~select
  int          m_cnt;     // pixels written into the current bank
  logic        m_full;    // completed bank not yet handed over
  logic        exp_wren;
  logic        exp_br;
  logic        exp_rst;
  int          exp_addr;
  logic [15:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pix_ready, advance model, check outputs
  task automatic cyc(input logic v, input logic [15:0] d, input logic s,
                     input logic dn, input logic r);
    pix_valid     = v;
    pix_data      = d;
    pix_sof       = s;
    consumer_done = dn;
    rst           = r;
    #1;
    chk("pix_ready", 32'(pix_ready), r ? 32'd0 : 32'(!m_full));
    exp_wren = 1'b0;
    exp_br   = 1'b0;
    exp_rst  = 1'b0;
    if (r) begin
      m_sel = 0; m_own = 0; m_cnt = 0; m_full = 0;
      exp_rst = 1'b1; exp_addr = 0; exp_data = '0;
    end else if (!m_full) begin
      if (v) begin
        exp_wren = 1'b1;
        exp_data = d;
        if (s) begin
          exp_addr = 0;
          m_cnt    = 1;
        end else begin
          exp_addr = m_cnt;
          m_cnt    = m_cnt + 1;
          if (m_cnt == DEPTH) m_full = 1'b1;
        end
      end
      if (dn) m_own = 1'b0;
    end else if (!m_own || dn) begin
      // handover of the completed bank
      m_sel  = ~m_sel;
      m_own  = 1'b1;
      m_cnt  = 0;
      m_full = 1'b0;
      exp_br = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("wren_a", 32'(wren_a), 32'(exp_wren));
    if (exp_wren || exp_rst) begin
      chk("address_a", 32'(address_a), 32'(exp_addr));
      chk("data_a", 32'(data_a), 32'(exp_data));
    end
    chk("bank_ready", 32'(bank_ready), 32'(exp_br));
    chk("select", 32'(select), 32'(m_sel));
    if (wren_a === 1'b1) n_wr++;
  endtask

  initial begin
    int w0;
    int guard;
    logic v;
    m_sel = 0; m_own = 0; m_cnt = 0; m_full = 0;
    exp_wren = 0; exp_br = 0; exp_rst = 0; exp_addr = 0; exp_data = '0;
    pix_valid = 0; pix_data = '0; pix_sof = 0; consumer_done = 0; rst = 1;
    @(posedge clk);
    #1;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // first bank, back-to-back, data = index, consumer not holding
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);  // flush bubble, swap follows

    // second bank with consumer holding: flush, wait, release 10 cycles later
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // bubbles: valid pattern 1,0,0 for 20 pixels
    w0 = n_wr;
    for (int i = 0; i < 60; i++) begin
      v = (i % 3 == 0);
      cyc(v, 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    chk("bubble_writes", 32'(n_wr - w0), 32'd20);

    // sof on what would be address 100
    for (int i = 0; i < 80; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      cyc(v, 16'($urandom), v && ($urandom_range(0, 999) == 0),
          ($urandom_range(0, 99) < 3), 1'b0);
    end

    // drive into WAIT (full bank, consumer still holding), then reset there
    guard = 0;
    while (!(m_full && m_own) && guard < 3000) begin
      cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_wait", 32'(guard < 3000), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pixel_mem_loader

// File: doc/pixel_mem_loader.md
# pixel_mem_loader

Upstream write stage for the dual-bank pixel memory. Accepts a 16-bit pixel stream over a valid/ready handshake and writes it sequentially into the memory's port A. Drives the memory's `select` line so banks ping-pong: port A fills one bank while the downstream consumer reads the other through port B. Hands each completed bank to the consumer and stalls the stream when the consumer has not yet released the previous one.

## Interface
Parameters:
- `DEPTH`, 512, words per bank; must equal 2**`ADDR_W`
- `ADDR_W`, 9, address width (matches memory port A)
- `DATA_W`, 16, pixel width (matches memory data port)

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  reset, synchronous, active-high
- `pix_data`  in  DATA_W  incoming pixel
- `pix_valid`  in  1  `pix_data` is valid
- `pix_sof`  in  1  start-of-frame; qualified by `pix_valid`
- `pix_ready`  out  1  loader accepts a pixel this cycle
- `consumer_done`  in  1  one-cycle pulse; consumer has finished reading the bank it holds
- `address_a`  out  ADDR_W  memory port A address (registered)
- `data_a`  out  DATA_W  memory port A write data (registered)
- `wren_a`  out  1  memory port A write enable (registered)
- `select`  out  1  bank currently being written by port A; consumer reads bank `~select`
- `bank_ready`  out  1  one-cycle pulse; bank `~select` has been handed to the consumer

## Operation
- Accept = `pix_valid & pix_ready`. Each accepted pixel is written at `wr_ptr`; `wr_ptr` then increments.
- Internal state: `wr_ptr[ADDR_W-1:0]`; `held`, set while the consumer owns bank `~select`.
- FSM states:
  - FILL: `pix_ready`=1.
    - Accepting at `wr_ptr`==DEPTH-1 without `pix_sof` moves to FLUSH.
    - `consumer_done` clears `held`.
  - FLUSH: `pix_ready`=0. The last word's write is presented to memory with the old `select`.
    - If `held`=0 or `consumer_done`=1: perform a swap, then go to FILL.
    - Otherwise go to WAIT.
  - WAIT: `pix_ready`=0. On `consumer_done`: perform a swap, then go to FILL.
- Swap: toggle `select`, pulse `bank_ready`, set `held`=1, set `wr_ptr`=0.
- `pix_sof` on an accepted pixel: the pixel is written at address 0 and `wr_ptr` becomes 1. The partial bank is abandoned in place and `select` is unchanged. `pix_sof` takes priority over the DEPTH-1 completion check.
- `consumer_done` while `held`=0 is ignored.
- The write path is a write-only port. `q_a` is not used.

## Timing
- Reset values: `select`=0, `address_a`=0, `data_a`=0, `wren_a`=0, `bank_ready`=0, `wr_ptr`=0, `held`=0, state FILL.
- `pix_ready` is 0 while `rst` is high, and 1 on the first cycle after `rst` deasserts.
- Latency: a pixel accepted in cycle N appears on `address_a`/`data_a` with `wren_a`=1 in cycle N+1. `wren_a` is 0 in every cycle following a non-accept.
- Throughput: 1 pixel/cycle within a bank. A bank takes at least DEPTH+1 cycles, because of the FLUSH bubble.
- `select` toggle and `bank_ready` pulse appear together, in the cycle after the swap condition (registered). They are never in the same cycle as a `wren_a` for the old bank.
- `consumer_done` arriving in the same cycle as the FLUSH evaluation is honoured: the swap happens without entering WAIT.
- `rst` in any state returns all outputs and state to reset values on the next edge. An in-flight write is dropped.
- `wr_ptr` never wraps silently: reaching DEPTH always passes through FLUSH.

## Structure
- Shared package `pixel_mem_pkg`:
  - constants `PIX_DEPTH`=512, `PIX_ADDR_W`=9, `PIX_DATA_W`=16
  - typedef `loader_state_t` {FILL, FLUSH, WAIT}
- One always_ff for state, pointers and registered outputs; one always_comb for next-state logic and `pix_ready`.
- No sub-module. The block is a single file.

## Test plan
- Reset check: hold `rst` 3 cycles, then release → `select`=0, `wren_a`=0, `bank_ready`=0, `pix_ready`=1 on the first cycle after release.
- Stream 512 back-to-back pixels, data = index, `held`=0:
  - `wren_a` high cycles 1–512 with `address_a` 0..511 and `data_a` = `address_a`
  - cycle 513: `pix_ready`=0
  - cycle 514: `select`=1, `bank_ready` pulse
- Second bank while `held`=1 → FLUSH then WAIT with `pix_ready`=0 held low. Pulse `consumer_done` 10 cycles later → next cycle `select`=0, `bank_ready`=1, `pix_ready`=1.
- Bubbles: `pix_valid` toggling 1,0,0,1… for 20 pixels → exactly 20 `wren_a` cycles, addresses 0..19 contiguous, no write on idle cycles.
- `pix_sof` on the 101st pixel (would be address 100) → written at address 0, next pixel at 1, `select` unchanged, no `bank_ready`.
- `rst` asserted during WAIT → next cycle all outputs at reset values. Subsequent stream starts at address 0 with `select`=0.
